// File: rtl/permute_pipe.sv
// Lane permutation pipeline: scatter or gather routing of N lanes of W bits,
// with valid/ready flow control, per-beat selector error flag, sticky error
// and an output handshake counter.

`ifndef P
`define P 2
`endif
`ifndef MAP
`define MAP 3
`endif

module permute_pipe #(
    parameter int unsigned N      = 2 * `P,
    parameter int unsigned W      = 1,
    parameter int unsigned SELW   = `MAP,
    parameter int unsigned MODE   = 0,
    parameter int unsigned STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*W-1:0]      in_bus,
    input  logic [N*SELW-1:0]   sel_bus,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*W-1:0]      out_bus,
    output logic                out_err,
    output logic                err_sticky,
    input  logic                err_clr,
    output logic [15:0]         xfer_cnt
);

    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  load;
    logic               ready_q;
    logic               out_fire;
    logic [15:0]        xfer_cnt_q;
    logic               err_sticky_q;

    // Permutation network source and result
    logic [N*W-1:0]     perm_src_data;
    logic [N*SELW-1:0]  perm_src_sel;
    logic [N*W-1:0]     perm_data;
    logic               perm_err;
    logic [SELW-1:0]    sel_j;
    int unsigned        idx_j;

    // Final stage contents
    logic [N*W-1:0]     last_data;
    logic               last_err;

    // Load enables ripple back from the output; stage 0 is also gated until
    // the first edge after reset so in_ready stays low through reset.
    always_comb begin
        load = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            if (k == int'(STAGES) - 1) begin
                load[k] = ~valid_q[k] | out_ready;
            end else begin
                load[k] = ~valid_q[k] | load[k+1];
            end
        end
        load[0] = load[0] & ready_q;
    end

    // Stage valid bits and the post-reset acceptance enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (load[0]) begin
                valid_q[0] <= in_valid;
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end
    end

    // Routing and selector checking; later lanes overwrite earlier ones so the
    // highest source lane wins a scatter collision.
    always_comb begin
        perm_data = '0;
        perm_err  = 1'b0;
        sel_j     = '0;
        idx_j     = 0;
        for (int j = 0; j < int'(N); j++) begin
            sel_j = perm_src_sel[j*SELW +: SELW];
            idx_j = 32'(sel_j);
            if (idx_j < N) begin
                if (MODE == 0) begin
                    perm_data[idx_j*W +: W] = perm_src_data[j*W +: W];
                    for (int k = 0; k < j; k++) begin
                        if (perm_src_sel[k*SELW +: SELW] == sel_j) begin
                            perm_err = 1'b1;
                        end
                    end
                end else begin
                    perm_data[j*W +: W] = perm_src_data[idx_j*W +: W];
                end
            end else begin
                perm_err = 1'b1;
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_single
            assign perm_src_data = in_bus;
            assign perm_src_sel  = sel_bus;

            // Single stage: the permuted result is registered straight from the inputs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    last_data <= '0;
                    last_err  <= 1'b0;
                end else if (load[0]) begin
                    last_data <= perm_data;
                    last_err  <= perm_err;
                end
            end
        end else begin : g_multi
            logic [N*W-1:0]    s0_data_q;
            logic [N*SELW-1:0] s0_sel_q;
            logic [N*W-1:0]    pd_q [STAGES-1];
            logic              pe_q [STAGES-1];

            assign perm_src_data = s0_data_q;
            assign perm_src_sel  = s0_sel_q;
            assign last_data     = pd_q[STAGES-2];
            assign last_err      = pe_q[STAGES-2];

            // Stage 0 captures raw lanes and selectors; later stages carry the result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0_data_q <= '0;
                    s0_sel_q  <= '0;
                    for (int k = 0; k < int'(STAGES) - 1; k++) begin
                        pd_q[k] <= '0;
                        pe_q[k] <= 1'b0;
                    end
                end else begin
                    if (load[0]) begin
                        s0_data_q <= in_bus;
                        s0_sel_q  <= sel_bus;
                    end
                    if (load[1]) begin
                        pd_q[0] <= perm_data;
                        pe_q[0] <= perm_err;
                    end
                    for (int k = 2; k < int'(STAGES); k++) begin
                        if (load[k]) begin
                            pd_q[k-1] <= pd_q[k-2];
                            pe_q[k-1] <= pe_q[k-2];
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_valid = valid_q[STAGES-1];
    assign out_bus   = last_data;
    assign out_err   = valid_q[STAGES-1] & last_err;
    assign in_ready  = load[0];
    assign out_fire  = out_valid & out_ready;

    // Output handshake bookkeeping; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q   <= 16'd0;
            err_sticky_q <= 1'b0;
        end else begin
            if (out_fire) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            if (out_fire && out_err) begin
                err_sticky_q <= 1'b1;
            end else if (err_clr) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign xfer_cnt   = xfer_cnt_q;
    assign err_sticky = err_sticky_q;

endmodule
